// File: rtl/dmem_mmio_responder.sv
// Data-memory responder for the core's M-stage port: word RAM plus an MMIO window
// (console TX FIFO, status, cycle counter, halt). Optional counter: define MMIO_CYCLE_EN.
module dmem_mmio_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter logic [31:0] MMIO_BASE   = 32'h0000_FF00,
  parameter int unsigned FIFO_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        halt
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned FW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = FW + 1;

  localparam logic [1:0] OFF_CONSOLE = 2'd0;
  localparam logic [1:0] OFF_STATUS  = 2'd1;
  localparam logic [1:0] OFF_CYCLE   = 2'd2;
  localparam logic [1:0] OFF_HALT    = 2'd3;

  localparam logic [CW-1:0] COUNT_FULL = CW'(FIFO_DEPTH);

  // Address decode
  logic          mmio_sel;
  logic [1:0]    mmio_off;
  logic [AW-1:0] ram_idx;
  logic          unused_adr_bits;

  assign mmio_sel        = (DataAdr[31:4] == MMIO_BASE[31:4]);
  assign mmio_off        = DataAdr[3:2];
  assign ram_idx         = DataAdr[AW+1:2];
  assign unused_adr_bits = ^DataAdr[1:0];

  logic ram_we;
  logic console_we;
  logic status_we;
  logic halt_we;

  assign ram_we     = MemWrite && !mmio_sel;
  assign console_we = MemWrite && mmio_sel && (mmio_off == OFF_CONSOLE);
  assign status_we  = MemWrite && mmio_sel && (mmio_off == OFF_STATUS);
  assign halt_we    = MemWrite && mmio_sel && (mmio_off == OFF_HALT);

  // Word RAM; contents survive reset
  logic [31:0] ram [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram[ram_idx] <= WriteData;
    end
  end

  // Console FIFO state
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [FW-1:0] rd_ptr;
  logic [FW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          overflow;

  logic fifo_full;
  logic fifo_empty;
  logic pop;
  logic push_ok;
  logic push_drop;

  assign fifo_full  = (count == COUNT_FULL);
  assign fifo_empty = (count == '0);
  assign pop        = !fifo_empty && tx_ready;
  assign push_ok    = console_we && !fifo_full;
  // A full FIFO drops the byte even when a pop frees a slot at the same edge
  assign push_drop  = console_we && fifo_full;

  assign tx_valid = !fifo_empty;
  assign tx_data  = fifo_empty ? 8'h00 : fifo_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem[wr_ptr] <= WriteData[7:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      halt     <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + FW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + FW'(1);
      end
      if (push_ok && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push_ok) begin
        count <= count - CW'(1);
      end
      if (push_drop) begin
        overflow <= 1'b1;
      end else if (status_we && WriteData[2]) begin
        overflow <= 1'b0;
      end
      if (halt_we) begin
        halt <= 1'b1;
      end
    end
  end

  // Free-running cycle counter; a CYCLE write loads instead of incrementing
  logic [31:0] cycle_rd;

`ifdef MMIO_CYCLE_EN
  logic        cycle_we;
  logic [31:0] cycle_cnt;

  assign cycle_we = MemWrite && mmio_sel && (mmio_off == OFF_CYCLE);
  assign cycle_rd = cycle_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_cnt <= '0;
    end else if (cycle_we) begin
      cycle_cnt <= WriteData;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
    end
  end
`else
  assign cycle_rd = 32'h0000_0000;
`endif

  logic [31:0] status_word;

  assign status_word = {16'h0000, 8'(count), 4'h0, halt, overflow, fifo_empty, fifo_full};

  // Zero-latency read path
  always_comb begin
    ReadData = 32'h0000_0000;
    if (mmio_sel) begin
      case (mmio_off)
        OFF_CONSOLE: ReadData = {24'h00_0000, tx_data};
        OFF_STATUS:  ReadData = status_word;
        OFF_CYCLE:   ReadData = cycle_rd;
        OFF_HALT:    ReadData = {31'h0000_0000, halt};
        default:     ReadData = 32'h0000_0000;
      endcase
    end else begin
      ReadData = ram[ram_idx];
    end
  end

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Bench for dmem_mmio_responder: vector table for RAM/MMIO reads, scoreboard for console drain.
module tb_dmem_mmio_responder;

  localparam logic [31:0] A_CON = 32'h0000_FF00;
  localparam logic [31:0] A_STA = 32'h0000_FF04;
  localparam logic [31:0] A_CYC = 32'h0000_FF08;
  localparam logic [31:0] A_HLT = 32'h0000_FF0C;

  logic        clk;
  logic        reset;
  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        halt;

  int n_checks;
  int n_errors;
  logic [7:0] sb [$];

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] wdata;
    logic        chk;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs [$];

  dmem_mmio_responder #(
    .DEPTH_WORDS(256),
    .MMIO_BASE  (32'h0000_FF00),
    .FIFO_DEPTH (8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .MemWrite (MemWrite),
    .DataAdr  (DataAdr),
    .WriteData(WriteData),
    .ReadData (ReadData),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .halt     (halt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Drain monitor: the handshake seen here completes at the next rising edge
  always @(negedge clk) begin
    if (reset && tx_valid && tx_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_pop: got %h expected no entry", tx_data);
      end else begin
        check("drain_order", {24'h0, tx_data}, {24'h0, sb.pop_front()});
      end
    end
  end

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    MemWrite  = 1'b1;
    DataAdr   = a;
    WriteData = d;
    @(posedge clk);
    #1;
    MemWrite  = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input string name, input logic [31:0] exp);
    MemWrite = 1'b0;
    DataAdr  = a;
    #1;
    check(name, ReadData, exp);
  endtask

  task automatic push_byte(input logic [7:0] b);
    if (sb.size() < 8) sb.push_back(b);
    wr(A_CON, {24'hABCDEF, b});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    reset     = 1'b1;
    MemWrite  = 1'b0;
    DataAdr   = A_STA;
    WriteData = 32'h0;
    tx_ready  = 1'b0;
    #1 reset = 1'b0;
    #1;
    check("reset_tx_valid", {31'h0, tx_valid}, 32'h0);
    check("reset_halt", {31'h0, halt}, 32'h0);
    check("reset_tx_data", {24'h0, tx_data}, 32'h0);
    check("reset_status", ReadData, 32'h0000_0002);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // Vector table: {we, addr, wdata, chk, expected ReadData before the edge}
    vecs.push_back('{1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 1'b0, 32'h0, "ram_wr40"});
    vecs.push_back('{1'b0, 32'h0000_0040, 32'h0,         1'b1, 32'hDEAD_BEEF, "ram_rd40"});
    vecs.push_back('{1'b0, 32'h0000_0440, 32'h0,         1'b1, 32'hDEAD_BEEF, "ram_wrap"});
    vecs.push_back('{1'b0, 32'h0000_0043, 32'h0,         1'b1, 32'hDEAD_BEEF, "ram_lowbits"});
    vecs.push_back('{1'b1, 32'h0000_0044, 32'h1234_5678, 1'b0, 32'h0, "ram_wr44"});
    vecs.push_back('{1'b0, 32'h0000_0044, 32'h0,         1'b1, 32'h1234_5678, "ram_rd44"});
    vecs.push_back('{1'b0, 32'h0000_0040, 32'h0,         1'b1, 32'hDEAD_BEEF, "ram_rd40_kept"});
    vecs.push_back('{1'b1, 32'h0000_FF10, 32'hA5A5_A5A5, 1'b0, 32'h0, "ram_wr_above_mmio"});
    vecs.push_back('{1'b0, 32'h0000_FF10, 32'h0,         1'b1, 32'hA5A5_A5A5, "ram_rd_above_mmio"});
    vecs.push_back('{1'b0, 32'h0000_0310, 32'h0,         1'b1, 32'hA5A5_A5A5, "ram_alias_above_mmio"});
    vecs.push_back('{1'b0, A_STA,         32'h0,         1'b1, 32'h0000_0002, "status_idle"});
    vecs.push_back('{1'b0, A_HLT,         32'h0,         1'b1, 32'h0, "halt_idle"});
    vecs.push_back('{1'b0, A_CON,         32'h0,         1'b1, 32'h0, "console_empty"});
    vecs.push_back('{1'b1, 32'h0000_0040, 32'h1111_1111, 1'b1, 32'hDEAD_BEEF, "ram_rd_during_wr"});
    vecs.push_back('{1'b0, 32'h0000_0040, 32'h0,         1'b1, 32'h1111_1111, "ram_rd_after_wr"});
    for (int i = 0; i < vecs.size(); i++) begin
      MemWrite  = vecs[i].we;
      DataAdr   = vecs[i].adr;
      WriteData = vecs[i].wdata;
      #1;
      if (vecs[i].chk) check(vecs[i].name, ReadData, vecs[i].exp);
      @(posedge clk);
      #1;
      MemWrite = 1'b0;
    end

    // FIFO ordering and back-to-back drain
    push_byte(8'h41);
    push_byte(8'h42);
    push_byte(8'h43);
    rd(A_STA, "status_three", 32'h0000_0300);
    rd(A_CON, "console_head", 32'h0000_0041);
    tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tx_ready = 1'b0;
    check("drained_tx_valid", {31'h0, tx_valid}, 32'h0);
    check("drained_sb_empty", sb.size(), 32'h0);
    rd(A_STA, "status_after_drain", 32'h0000_0002);

    // Overflow, push-while-empty latency, full+pop+push drop
    sb.push_back(8'h50);
    MemWrite  = 1'b1;
    DataAdr   = A_CON;
    WriteData = 32'h0000_0050;
    #1;
    check("no_fallthrough", {31'h0, tx_valid}, 32'h0);
    @(posedge clk);
    #1;
    MemWrite = 1'b0;
    check("valid_next_cycle", {31'h0, tx_valid}, 32'h1);
    for (int b = 8'h51; b <= 8'h58; b++) push_byte(8'(b));
    rd(A_STA, "status_overflow", 32'h0000_0805);
    wr(A_STA, 32'h0000_0004);
    rd(A_STA, "status_ovf_cleared", 32'h0000_0801);
    tx_ready = 1'b1;
    push_byte(8'h60);
    rd(A_STA, "status_full_pop_push", 32'h0000_0704);
    repeat (7) @(posedge clk);
    #1;
    tx_ready = 1'b0;
    check("ovf_drained_tx_valid", {31'h0, tx_valid}, 32'h0);
    check("ovf_drained_sb_empty", sb.size(), 32'h0);
    wr(A_STA, 32'h0000_0004);
    rd(A_STA, "status_clean", 32'h0000_0002);

    // Simultaneous push and pop with count=3
    push_byte(8'h70);
    push_byte(8'h71);
    push_byte(8'h72);
    tx_ready = 1'b1;
    push_byte(8'h73);
    tx_ready = 1'b0;
    rd(A_STA, "status_simul", 32'h0000_0300);
    rd(A_CON, "console_simul_head", 32'h0000_0071);
    tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tx_ready = 1'b0;
    check("simul_drained_tx_valid", {31'h0, tx_valid}, 32'h0);
    check("simul_sb_empty", sb.size(), 32'h0);

    // Cycle counter
`ifdef MMIO_CYCLE_EN
    wr(A_CYC, 32'hFFFF_FFFE);
    rd(A_CYC, "cycle_load", 32'hFFFF_FFFE);
    @(posedge clk);
    #1;
    check("cycle_inc", ReadData, 32'hFFFF_FFFF);
    @(posedge clk);
    #1;
    check("cycle_wrap", ReadData, 32'h0000_0000);
`else
    rd(A_CYC, "cycle_absent", 32'h0);
    wr(A_CYC, 32'h1234_5678);
    rd(A_CYC, "cycle_absent_wr", 32'h0);
`endif

    // Halt: any write, sticky
    MemWrite  = 1'b1;
    DataAdr   = A_HLT;
    WriteData = 32'h0;
    #1;
    check("halt_before_edge", {31'h0, halt}, 32'h0);
    @(posedge clk);
    #1;
    MemWrite = 1'b0;
    check("halt_set", {31'h0, halt}, 32'h1);
    rd(A_HLT, "halt_read", 32'h1);
    @(posedge clk);
    #1;
    check("halt_sticky", {31'h0, halt}, 32'h1);

    // Asynchronous reset mid-cycle with bytes queued
    for (int b = 8'h80; b <= 8'h84; b++) push_byte(8'(b));
    rd(A_STA, "status_pre_reset", 32'h0000_0508);
    #2;
    reset = 1'b0;
    #1;
    check("areset_tx_valid", {31'h0, tx_valid}, 32'h0);
    check("areset_halt", {31'h0, halt}, 32'h0);
    check("areset_tx_data", {24'h0, tx_data}, 32'h0);
    check("areset_status", ReadData, 32'h0000_0002);
`ifdef MMIO_CYCLE_EN
    rd(A_CYC, "areset_cycle", 32'h0);
`endif
    sb.delete();
    @(posedge clk);
    #1;
    reset = 1'b1;
    rd(32'h0000_0040, "ram_retained", 32'h1111_1111);
    @(posedge clk);
    #1;
    check("post_reset_tx_valid", {31'h0, tx_valid}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dmem_mmio_responder.md
Name: dmem_mmio_responder

Overview:
- Data-memory responder for the pipelined core's M-stage data port. It is the other end of the core's MemWrite/DataAdr/WriteData/ReadData interface.
- Serves a word-addressed RAM plus a small MMIO window:
  - console TX FIFO with a valid/ready drain
  - status register
  - halt flag
  - optional free-running cycle counter
- Sits beside the core at the top level; the console drain connects to a UART or testbench sink.

Parameters:
- DEPTH_WORDS, 256, RAM size in 32-bit words; power of 2.
- MMIO_BASE, 32'h0000_FF00, byte address of the MMIO window (16 bytes). Addresses below it map to RAM.
- FIFO_DEPTH, 8, console FIFO entries; power of 2, ≥2.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- MemWrite  in  1  write strobe from core (M stage).
- DataAdr  in  32  byte address; bits [1:0] ignored (word access only).
- WriteData  in  32  store data.
- ReadData  out  32  load data; combinational from DataAdr.
- tx_data  out  8  FIFO head byte.
- tx_valid  out  1  FIFO non-empty.
- tx_ready  in  1  sink accepts head when tx_valid && tx_ready at a clock edge.
- halt  out  1  sticky halt flag.

Behaviour:
- Decode: mmio_sel = (DataAdr[31:4] == MMIO_BASE[31:4]).
  - RAM index = DataAdr[log2(DEPTH_WORDS)+1:2]; upper bits ignored, so out-of-range addresses wrap modulo DEPTH_WORDS.
  - Addresses ≥ MMIO_BASE+16 map to RAM.
- Reads: zero-latency combinational; ReadData is valid in the same cycle DataAdr is valid, regardless of MemWrite.
- Writes take effect at the clock edge while MemWrite=1. A read of the same address in that cycle returns the old value.
- MMIO map (offset = DataAdr[3:2]):
  - 0 CONSOLE
    - Write pushes WriteData[7:0] into the FIFO.
    - Read returns {24'b0, head byte}, or 0 if empty; reading does not pop.
  - 1 STATUS
    - Read bits: [0] full, [1] empty, [2] overflow (sticky), [3] halt, [15:8] count, others 0.
    - Write with WriteData[2]=1 clears overflow; other bits are ignored.
  - 2 CYCLE
    - Read returns the counter.
    - Write loads WriteData at the edge; it increments from there on following cycles.
  - 3 HALT
    - Any write sets halt=1; it stays 1 until reset.
    - Read returns {31'b0, halt}.
- FIFO:
  - Circular buffer with read/write pointers and a count of width log2(FIFO_DEPTH)+1; pointers wrap at FIFO_DEPTH.
  - Pop when tx_valid && tx_ready. Push on a CONSOLE write.
  - Push while full (count==FIFO_DEPTH): byte dropped and overflow set. This holds even if a pop occurs in the same cycle; the pop still happens.
  - Push and pop in the same cycle when 0<count<FIFO_DEPTH: count unchanged, both pointers advance.
  - Push while empty: tx_valid rises on the next cycle (no fall-through).
  - tx_data is stable while tx_valid=1 and the entry has not been popped.
- Cycle counter: +1 every cycle, wraps 32'hFFFF_FFFF→0. A write overrides the increment that cycle.
- Reset (reset=0, asynchronous):
  - FIFO pointers and count = 0; tx_valid=0; tx_data=0.
  - overflow=0, halt=0, counter=0.
  - RAM contents are not cleared.
  - Reset mid-drain discards all queued bytes immediately.

Optional Feature:
- Macro MMIO_CYCLE_EN.
- Defined: CYCLE register implemented as above.
- Undefined: no counter flops; CYCLE reads 0 and writes to it are ignored.

Test Plan:
- RAM: write 32'hDEADBEEF to 0x40, then read 0x40 → ReadData=32'hDEADBEEF. Read 0x40+4*DEPTH_WORDS → same value (wrap).
- FIFO order: tx_ready=0, push 0x41,0x42,0x43 → STATUS=0x0300. Raise tx_ready → tx_data 0x41,0x42,0x43 on consecutive cycles, then tx_valid=0 and STATUS=0x0002.
- Overflow: tx_ready=0, push 9 bytes with FIFO_DEPTH=8 → STATUS=0x0805, 9th byte absent from drain. Write STATUS 0x4 → bit2 cleared.
- Simultaneous: count=3, tx_ready=1 and push the same cycle → count stays 3, order preserved.
- Counter (MMIO_CYCLE_EN): write CYCLE=32'hFFFF_FFFE → reads FFFF_FFFE, FFFF_FFFF, 0 on successive cycles. Without the macro, reads 0.
- Async reset: reset=0 mid-cycle with 5 bytes queued and halt=1 → tx_valid=0, halt=0, STATUS=0x0002 immediately, without waiting for a clock edge. RAM data at 0x40 retained.
